// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register specifiers and the hazard sequencer state encoding.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is a source of the instr in ID.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_dREN,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     hazard
);

    // $zero is never a real dependency, so a load targeting r0 never stalls
    always_comb begin
        hazard = ex_dREN && (ex_wsel != '0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional perf counters (stall_cnt, flush_cnt) are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_jump,
    input  logic     ex_dREN,
    input  regbits_t ex_wsel,
    input  logic     mem_dREN,
    input  logic     mem_dWEN,
    input  logic     mem_br_taken,
    input  logic     wb_halt,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     ifid_flush,
    output logic     idex_en,
    output logic     idex_flush,
    output logic     exmem_en,
    output logic     exmem_flush,
    output logic     memwb_en,
    output logic     memwb_flush,
    output logic     halt
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_t state_q, state_d;
    logic        halt_q, halt_d;
    logic        load_use;
    logic        mem_stall;
    logic        stall_evt;
    logic        flush_evt;

    load_use_detect u_load_use_detect (
        .ex_dREN (ex_dREN),
        .ex_wsel (ex_wsel),
        .id_rs   (id_rs),
        .id_rt   (id_rt),
        .hazard  (load_use)
    );

    assign mem_stall = (mem_dREN || mem_dWEN) && !dhit;

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (state_q != HALTED) begin
            if (wb_halt) begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end else if (state_q == RUN && mem_stall) begin
                state_d = MEMWAIT;
            end else if (state_q == MEMWAIT && dhit) begin
                state_d = RUN;
            end
        end
    end

    // Flushed registers also get en=0 so flush dominance never matters downstream
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        if (!nRST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (state_q == HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
            stall_evt   = 1'b1;
        end else if (mem_br_taken) begin
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            flush_evt   = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            idex_flush = 1'b1;
            stall_evt  = 1'b1;
        end else if (id_jump) begin
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            stall_evt  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    assign halt = halt_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Events are already suppressed in HALTED and reset, which freezes the counters
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_evt);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_evt);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    logic             unused_evt;
    assign unused_cnt_w = '0;
    assign unused_evt   = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected control vectors queued at drive time, checked at sample time.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, id_jump, ex_dREN, mem_dREN, mem_dWEN, mem_br_taken, wb_halt;
    logic [4:0] id_rs, id_rt, ex_wsel;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_jump      (id_jump),
        .ex_dREN      (ex_dREN),
        .ex_wsel      (ex_wsel),
        .mem_dREN     (mem_dREN),
        .mem_dWEN     (mem_dWEN),
        .mem_br_taken (mem_br_taken),
        .wb_halt      (wb_halt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .exmem_flush  (exmem_flush),
        .memwb_en     (memwb_en),
        .memwb_flush  (memwb_flush),
        .halt         (halt)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    typedef struct packed {
        logic       nrst;
        logic       ihit;
        logic       dhit;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       jump;
        logic       exdren;
        logic [4:0] wsel;
        logic       mdren;
        logic       mdwen;
        logic       br;
        logic       whalt;
    } stim_t;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush, halt}
    localparam logic [9:0] E_RST   = 10'b0_01_01_01_01_0;
    localparam logic [9:0] E_RUN   = 10'b1_10_10_10_10_0;
    localparam logic [9:0] E_MEMST = 10'b0_00_00_00_01_0;
    localparam logic [9:0] E_BR    = 10'b1_01_01_01_10_0;
    localparam logic [9:0] E_LU    = 10'b0_00_01_10_10_0;
    localparam logic [9:0] E_JMP   = 10'b1_01_10_10_10_0;
    localparam logic [9:0] E_MISS  = 10'b0_01_10_10_10_0;
    localparam logic [9:0] E_HALT  = 10'b0_00_00_00_00_1;

    logic [9:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic step(input string tag, input stim_t s, input logic [9:0] exp);
        logic [9:0] got;
        logic [9:0] e;
        @(negedge CLK);
        nRST         = s.nrst;
        ihit         = s.ihit;
        dhit         = s.dhit;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_jump      = s.jump;
        ex_dREN      = s.exdren;
        ex_wsel      = s.wsel;
        mem_dREN     = s.mdren;
        mem_dWEN     = s.mdwen;
        mem_br_taken = s.br;
        wb_halt      = s.whalt;
        exp_q.push_back(exp);
        #2;
        got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halt};
        e = exp_q.pop_front();
        n_assert++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, e);
        end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef);
        @(posedge CLK);
        #1;
        n_assert++;
        assert (stall_cnt === es) else begin
            n_fail++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, es);
        end
        n_assert++;
        assert (flush_cnt === ef) else begin
            n_fail++;
            $error("FAIL %s flush_cnt: observed %0d expected %0d", tag, flush_cnt, ef);
        end
    endtask
`endif

    stim_t idle, s;

    initial begin
        idle = '{nrst: 1'b1, ihit: 1'b1, dhit: 1'b0, rs: 5'd1, rt: 5'd2, jump: 1'b0,
                 exdren: 1'b0, wsel: 5'd3, mdren: 1'b0, mdwen: 1'b0, br: 1'b0, whalt: 1'b0};
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; id_rs = '0; id_rt = '0; id_jump = 1'b0;
        ex_dREN = 1'b0; ex_wsel = '0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_br_taken = 1'b0; wb_halt = 1'b0;

        s = idle; s.nrst = 1'b0;
        for (int i = 0; i < 3; i++) step("reset_hold", s, E_RST);
        step("reset_release", idle, E_RUN);
        step("run_idle", idle, E_RUN);

        s = idle; s.exdren = 1'b1; s.wsel = 5'd8; s.rs = 5'd8;
        step("load_use_rs", s, E_LU);
        step("after_load_use", idle, E_RUN);
        s = idle; s.exdren = 1'b1; s.wsel = 5'd8; s.rt = 5'd8;
        step("load_use_rt", s, E_LU);
        s = idle; s.exdren = 1'b1; s.wsel = 5'd0; s.rs = 5'd0;
        step("load_r0_no_stall", s, E_RUN);
        s = idle; s.exdren = 1'b0; s.wsel = 5'd8; s.rs = 5'd8;
        step("no_load_no_stall", s, E_RUN);

        s = idle; s.mdren = 1'b1; s.dhit = 1'b1;
        step("single_cycle_hit", s, E_RUN);
        s = idle; s.mdren = 1'b1;
        for (int i = 0; i < 4; i++) step("mem_wait", s, E_MEMST);
        s.dhit = 1'b1;
        step("mem_done", s, E_RUN);
        step("after_mem", idle, E_RUN);
        s = idle; s.mdwen = 1'b1;
        step("store_wait", s, E_MEMST);
        s = idle; s.mdwen = 1'b1; s.br = 1'b1; s.exdren = 1'b1; s.wsel = 5'd4; s.rs = 5'd4;
        step("mem_stall_over_branch", s, E_MEMST);

        s = idle; s.br = 1'b1; s.exdren = 1'b1; s.wsel = 5'd8; s.rs = 5'd8;
        step("branch_over_load_use", s, E_BR);
        s = idle; s.br = 1'b1; s.ihit = 1'b0;
        step("branch_over_miss", s, E_BR);
        s = idle; s.jump = 1'b1;
        step("jump", s, E_JMP);
        s = idle; s.jump = 1'b1; s.exdren = 1'b1; s.wsel = 5'd9; s.rt = 5'd9;
        step("load_use_over_jump", s, E_LU);
        s = idle; s.jump = 1'b1; s.ihit = 1'b0;
        step("jump_over_miss", s, E_JMP);
        s = idle; s.ihit = 1'b0;
        step("icache_miss", s, E_MISS);

        s = idle; s.mdren = 1'b1;
        step("mem_wait_pre_reset", s, E_MEMST);
        s.nrst = 1'b0;
        step("reset_mid_memwait", s, E_RST);
        step("run_after_reset", idle, E_RUN);

        s = idle; s.ihit = 1'b0;
        for (int i = 0; i < 5; i++) step("perf_miss", s, E_MISS);
        s = idle; s.jump = 1'b1;
        for (int i = 0; i < 2; i++) step("perf_jump", s, E_JMP);
`ifdef PIPE_PERF_CNT_EN
        chk_cnt("perf_counts", 5, 2);
`endif

        s = idle; s.whalt = 1'b1;
        step("halt_pulse", s, E_RUN);
        s = idle; s.ihit = 1'b0;
        step("halted_miss", s, E_HALT);
        s = idle; s.mdren = 1'b1;
        step("halted_mem", s, E_HALT);
        s = idle; s.br = 1'b1;
        step("halted_branch", s, E_HALT);
        step("halted_idle", idle, E_HALT);
`ifdef PIPE_PERF_CNT_EN
        chk_cnt("perf_frozen", 5, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
